// File: rtl/trig_cond_pkg.sv
// Shared types, default parameters and sizing helper for the trigger input conditioner.
`timescale 1ns/1ps
package trig_cond_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    Q_RISE = 2'd1,
    HIGH   = 2'd2,
    Q_FALL = 2'd3
  } chan_state_t;

  localparam int DEF_N_CH           = 3;
  localparam int DEF_FILTER_CYCLES  = 4;
  localparam int DEF_HOLDOFF_CYCLES = 50;
  localparam int DEF_CNT_W          = 16;

  // Ceil(log2(value)), never less than 1 so a zero-range counter still has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/trig_channel_filter.sv
// One trigger channel: 2-FF synchroniser, glitch-qualifying FSM, rise holdoff and rise counter.
`timescale 1ns/1ps
module trig_channel_filter
  import trig_cond_pkg::*;
#(
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             trig_in,
  input  logic             ch_enable,
  input  logic             clear_counts,
  output logic             trig_level,
  output logic             trig_rise,
  output logic             trig_fall,
  output logic             holdoff_busy,
  output logic [CNT_W-1:0] rise_count
);
  localparam int QW = clog2(FILTER_CYCLES + 1);
  localparam int TW = clog2(HOLDOFF_CYCLES + 1);
  localparam logic [QW-1:0] Q_TARGET = QW'(FILTER_CYCLES);
  localparam logic [TW-1:0] T_LOAD   = TW'(HOLDOFF_CYCLES);

  logic              sync1_r, sync2_r;
  chan_state_t       state_r, state_s;
  logic [QW-1:0]     qcnt_r, qcnt_s;
  logic              rise_evt_r, rise_evt_s, fall_evt_r, fall_evt_s;
  logic              rise_emit_s;
  logic [TW-1:0]     timer_r, timer_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              level_r, rise_r, fall_r, busy_r;

  // Plain two-flop synchroniser; nothing may sit between the flops.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= trig_in;
      sync2_r <= sync1_r;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= LOW;
      qcnt_r     <= {QW{1'b0}};
      rise_evt_r <= 1'b0;
      fall_evt_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      qcnt_r     <= qcnt_s;
      rise_evt_r <= rise_evt_s;
      fall_evt_r <= fall_evt_s;
    end
  end

  always_comb begin
    state_s    = state_r;
    qcnt_s     = qcnt_r;
    rise_evt_s = 1'b0;
    fall_evt_s = 1'b0;
    case (state_r)
      LOW: begin
        if (!sync2_r) begin
          qcnt_s = {QW{1'b0}};
        end else if (Q_TARGET == QW'(1)) begin
          state_s    = HIGH;
          rise_evt_s = 1'b1;
        end else begin
          state_s = Q_RISE;
          qcnt_s  = QW'(1);
        end
      end
      Q_RISE: begin
        if (!sync2_r) begin
          state_s = LOW;
        end else if (qcnt_r + QW'(1) == Q_TARGET) begin
          state_s    = HIGH;
          rise_evt_s = 1'b1;
        end else begin
          qcnt_s = qcnt_r + QW'(1);
        end
      end
      HIGH: begin
        if (sync2_r) begin
          qcnt_s = {QW{1'b0}};
        end else if (Q_TARGET == QW'(1)) begin
          state_s    = LOW;
          fall_evt_s = 1'b1;
        end else begin
          state_s = Q_FALL;
          qcnt_s  = QW'(1);
        end
      end
      Q_FALL: begin
        if (sync2_r) begin
          state_s = HIGH;
        end else if (qcnt_r + QW'(1) == Q_TARGET) begin
          state_s    = LOW;
          fall_evt_s = 1'b1;
        end else begin
          qcnt_s = qcnt_r + QW'(1);
        end
      end
      default: begin
        state_s = LOW;
        qcnt_s  = {QW{1'b0}};
      end
    endcase
  end

  // A rise is only strobed, counted and allowed to arm the holdoff when it is emitted.
  always_comb begin
    rise_emit_s = rise_evt_r & ch_enable & (timer_r == {TW{1'b0}});
    if (rise_emit_s) begin
      timer_s = T_LOAD;
    end else if (timer_r != {TW{1'b0}}) begin
      timer_s = timer_r - TW'(1);
    end else begin
      timer_s = timer_r;
    end
    if (clear_counts) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (rise_emit_s && !(&cnt_r)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      timer_r <= {TW{1'b0}};
      busy_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      level_r <= (state_r == HIGH) || (state_r == Q_FALL);
      rise_r  <= rise_emit_s;
      fall_r  <= fall_evt_r & ch_enable;
      timer_r <= timer_s;
      busy_r  <= (timer_s != {TW{1'b0}});
      cnt_r   <= cnt_s;
    end
  end

  assign trig_level   = level_r;
  assign trig_rise    = rise_r;
  assign trig_fall    = fall_r;
  assign holdoff_busy = busy_r;
  assign rise_count   = cnt_r;

endmodule

// File: rtl/trig_input_conditioner.sv
// Conditions N_CH asynchronous trigger lines into clean level/strobe outputs and rise counters.
`timescale 1ns/1ps
module trig_input_conditioner
  import trig_cond_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       trig_in,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic                  clear_counts,
  output logic [N_CH-1:0]       trig_level,
  output logic [N_CH-1:0]       trig_rise,
  output logic [N_CH-1:0]       trig_fall,
  output logic [N_CH-1:0]       holdoff_busy,
  output logic [N_CH*CNT_W-1:0] rise_count
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    trig_channel_filter #(
      .FILTER_CYCLES  (FILTER_CYCLES),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .CLOCK_50     (CLOCK_50),
      .reset_n      (reset_n),
      .trig_in      (trig_in[k]),
      .ch_enable    (ch_enable[k]),
      .clear_counts (clear_counts),
      .trig_level   (trig_level[k]),
      .trig_rise    (trig_rise[k]),
      .trig_fall    (trig_fall[k]),
      .holdoff_busy (holdoff_busy[k]),
      .rise_count   (rise_count[k*CNT_W +: CNT_W])
    );
  end

endmodule
